// File: rtl/memory_bus_adapter_if.sv
// Station-side request/response and external bus signal bundles.
// master modport = initiator of the handshake; slave modport = responder.
interface mem_req_if #(parameter int SIZE = 32);
  logic            memory_enable;
  logic            memory_operation;
  logic [1:0]      memory_data_size;
  logic [SIZE-1:0] memory_address;
  logic [SIZE-1:0] memory_data_out;
  logic            memory_ready;
  logic [SIZE-1:0] memory_data_in;

  modport master (
    output memory_enable, memory_operation, memory_data_size, memory_address, memory_data_out,
    input  memory_ready, memory_data_in
  );
  modport slave (
    input  memory_enable, memory_operation, memory_data_size, memory_address, memory_data_out,
    output memory_ready, memory_data_in
  );
endinterface

interface mem_bus_if #(parameter int SIZE = 32);
  logic            bus_request;
  logic            bus_write;
  logic [SIZE-1:0] bus_address;
  logic [3:0]      bus_byte_enable;
  logic [SIZE-1:0] bus_write_data;
  logic            bus_acknowledge;
  logic [SIZE-1:0] bus_read_data;

  modport master (
    output bus_request, bus_write, bus_address, bus_byte_enable, bus_write_data,
    input  bus_acknowledge, bus_read_data
  );
  modport slave (
    input  bus_request, bus_write, bus_address, bus_byte_enable, bus_write_data,
    output bus_acknowledge, bus_read_data
  );
endinterface

// File: rtl/memory_bus_adapter.sv
// Turns one load/store request into one or two word-aligned byte-enable bus beats.
// Latency 2 edges (3 when split) plus bus wait states; bus_request is held until acknowledged.
module memory_bus_adapter #(
  parameter int SIZE = 32
) (
  input  logic      clock,
  input  logic      reset,
  mem_req_if.slave  req,
  mem_bus_if.master bus
);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} state_t;

  state_t          state_q, state_nxt;
  logic            op_q, op_nxt;
  logic [1:0]      size_q, size_nxt;
  logic [1:0]      offs_q, offs_nxt;
  logic            split_q, split_nxt;
  logic            flush_q, flush_nxt;
  logic [3:0]      be_hi_q, be_hi_nxt;
  logic [SIZE-1:0] wdat_hi_q, wdat_hi_nxt;
  logic [SIZE-1:0] lo_q, lo_nxt;

  logic            ready_q, ready_nxt;
  logic [SIZE-1:0] data_in_q, data_in_nxt;
  logic            request_q, request_nxt;
  logic            write_q, write_nxt;
  logic [SIZE-1:0] address_q, address_nxt;
  logic [3:0]      be_q, be_nxt;
  logic [SIZE-1:0] wdat_q, wdat_nxt;

  logic [3:0]        lane_mask;
  logic [7:0]        be_wide;
  logic [2*SIZE-1:0] dat_wide;
  logic [SIZE+23:0]  fin_word;
  logic [SIZE-1:0]   fin_data;
  logic              finishing;

  // Lanes spill into the next word when the shifted mask reaches bits [7:4].
  always_comb begin
    case (req.memory_data_size)
      2'd0:    lane_mask = 4'b0001;
      2'd1:    lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
    be_wide  = {4'b0000, lane_mask} << req.memory_address[1:0];
    dat_wide = {{SIZE{1'b0}}, req.memory_data_out} << {req.memory_address[1:0], 3'b000};
  end

  // Load result: the only bytes ever selected lie below bit 8*3+32.
  always_comb begin
    if (state_q == BEAT2) fin_word = {bus.bus_read_data[23:0], lo_q};
    else                  fin_word = {24'd0, bus.bus_read_data};
    fin_data = fin_word[{offs_q, 3'b000} +: SIZE];
    case (size_q)
      2'd0:    fin_data = fin_data & 32'h0000_00FF;
      2'd1:    fin_data = fin_data & 32'h0000_FFFF;
      default: fin_data = fin_data;
    endcase
  end

  assign finishing = bus.bus_acknowledge && request_q &&
                     ((state_q == BEAT2) || (state_q == BEAT1 && !split_q));

  always_comb begin
    state_nxt   = state_q;
    op_nxt      = op_q;
    size_nxt    = size_q;
    offs_nxt    = offs_q;
    split_nxt   = split_q;
    flush_nxt   = flush_q;
    be_hi_nxt   = be_hi_q;
    wdat_hi_nxt = wdat_hi_q;
    lo_nxt      = lo_q;
    ready_nxt   = ready_q;
    data_in_nxt = data_in_q;
    request_nxt = request_q;
    write_nxt   = write_q;
    address_nxt = address_q;
    be_nxt      = be_q;
    wdat_nxt    = wdat_q;

    case (state_q)
      IDLE: begin
        if (req.memory_enable) begin
          if (req.memory_data_size != 2'd3) begin
            state_nxt   = BEAT1;
            op_nxt      = req.memory_operation;
            size_nxt    = req.memory_data_size;
            offs_nxt    = req.memory_address[1:0];
            split_nxt   = (be_wide[7:4] != 4'b0000);
            flush_nxt   = 1'b0;
            be_hi_nxt   = be_wide[7:4];
            wdat_hi_nxt = dat_wide[2*SIZE-1:SIZE];
            lo_nxt      = '0;
            request_nxt = 1'b1;
            write_nxt   = req.memory_operation;
            address_nxt = {req.memory_address[SIZE-1:2], 2'b00};
            be_nxt      = be_wide[3:0];
            wdat_nxt    = dat_wide[SIZE-1:0];
          end else begin
            state_nxt   = DONE;
            ready_nxt   = 1'b1;
            data_in_nxt = '0;
          end
        end
      end
      BEAT1, BEAT2: begin
        if (!req.memory_enable) flush_nxt = 1'b1;
        if (bus.bus_acknowledge && state_q == BEAT1) lo_nxt = bus.bus_read_data;
        if (bus.bus_acknowledge && state_q == BEAT1 && split_q) begin
          state_nxt   = BEAT2;
          address_nxt = address_q + 32'd4;
          be_nxt      = be_hi_q;
          wdat_nxt    = wdat_hi_q;
        end
        if (finishing) begin
          request_nxt = 1'b0;
          write_nxt   = 1'b0;
          address_nxt = '0;
          be_nxt      = '0;
          wdat_nxt    = '0;
          // A flushed request still completes its beats but never reports back.
          if (flush_q || !req.memory_enable) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = DONE;
            ready_nxt   = 1'b1;
            data_in_nxt = op_q ? '0 : fin_data;
          end
        end
      end
      DONE: begin
        if (!req.memory_enable) begin
          state_nxt   = IDLE;
          ready_nxt   = 1'b0;
          data_in_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      size_q    <= '0;
      offs_q    <= '0;
      split_q   <= 1'b0;
      flush_q   <= 1'b0;
      be_hi_q   <= '0;
      wdat_hi_q <= '0;
      lo_q      <= '0;
      ready_q   <= 1'b0;
      data_in_q <= '0;
      request_q <= 1'b0;
      write_q   <= 1'b0;
      address_q <= '0;
      be_q      <= '0;
      wdat_q    <= '0;
    end else begin
      state_q   <= state_nxt;
      op_q      <= op_nxt;
      size_q    <= size_nxt;
      offs_q    <= offs_nxt;
      split_q   <= split_nxt;
      flush_q   <= flush_nxt;
      be_hi_q   <= be_hi_nxt;
      wdat_hi_q <= wdat_hi_nxt;
      lo_q      <= lo_nxt;
      ready_q   <= ready_nxt;
      data_in_q <= data_in_nxt;
      request_q <= request_nxt;
      write_q   <= write_nxt;
      address_q <= address_nxt;
      be_q      <= be_nxt;
      wdat_q    <= wdat_nxt;
    end
  end

  assign req.memory_ready    = ready_q;
  assign req.memory_data_in  = data_in_q;
  assign bus.bus_request     = request_q;
  assign bus.bus_write       = write_q;
  assign bus.bus_address     = address_q;
  assign bus.bus_byte_enable = be_q;
  assign bus.bus_write_data  = wdat_q;

endmodule
